// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed clock display: active-low glyphs,
// digit slot indices and the blink phase type.
package clock_disp_pkg;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [2:0] DIG_S0 = 3'd0;
    localparam logic [2:0] DIG_S1 = 3'd1;
    localparam logic [2:0] DIG_M0 = 3'd2;
    localparam logic [2:0] DIG_M1 = 3'd3;
    localparam logic [2:0] DIG_H0 = 3'd4;
    localparam logic [2:0] DIG_H1 = 3'd5;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

endpackage

// File: rtl/clock_display_scan_seg7.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit common-anode scan driver with per-frame digit snapshot,
// per-slot blanking gap, leading-zero blanking and alarm flash.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 10000,
    parameter int BLANK_CYC    = 100,
    parameter int BLINK_FRAMES = 83,
    parameter int LZB          = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       Alarm,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [15:0] SLOT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END  = 16'(BLANK_CYC);
    localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

    logic [15:0]     slot_cnt;
    logic [2:0]      idx;
    logic [7:0]      frame_cnt;
    phase_t          phase;
    logic            first_cyc;
    logic [5:0][3:0] snap;
    logic [3:0]      cur_digit;
    logic [6:0]      dec_seg;
    logic            slot_wrap;
    logic            frame_wrap;
    logic            blank_slot;
    logic            flash_off;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx == DIG_H1);

    // first_cyc sits at 1 through reset so the digits are captured on the
    // first clock after release, before any lit cycle of the first frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt  <= '0;
            idx       <= '0;
            first_cyc <= 1'b1;
            snap      <= '0;
        end else begin
            first_cyc <= 1'b0;
            slot_cnt  <= slot_wrap ? 16'd0 : slot_cnt + 16'd1;
            if (slot_wrap)
                idx <= (idx == DIG_H1) ? 3'd0 : idx + 3'd1;
            if (first_cyc || frame_wrap)
                snap <= {{2'b00, H_in1}, H_in0, M_in1, M_in0, S_in1, S_in0};
        end
    end

    // Alarm low takes priority over a coincident frame terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            phase     <= PH_ON;
        end else if (!Alarm) begin
            frame_cnt <= '0;
            phase     <= PH_ON;
        end else if (frame_wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        cur_digit = snap[0];
        case (idx)
            DIG_S1:  cur_digit = snap[1];
            DIG_M0:  cur_digit = snap[2];
            DIG_M1:  cur_digit = snap[3];
            DIG_H0:  cur_digit = snap[4];
            DIG_H1:  cur_digit = snap[5];
            default: cur_digit = snap[0];
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    assign blank_slot = (slot_cnt < BLANK_END) ||
                        ((LZB != 0) && (idx == DIG_H1) && (snap[5] == 4'd0));
    // Gating with Alarm directly lets a falling Alarm relight the very next cycle.
    assign flash_off  = Alarm && (phase == PH_OFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 6'b111111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (blank_slot || flash_off) begin
            an  <= 6'b111111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(6'b000001 << idx);
            seg <= dec_seg;
            dp  <= !((idx == DIG_H0) || (idx == DIG_M0));
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Frame-level bench for clock_display_scan with small scan parameters.
module tb_clock_display_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int W            = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
    logic       Alarm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    // Expected entry: {an[5:0], seg[6:0], dp, seg_checked}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int checks   = 0;
    int failures = 0;
    int samples  = 0;
    int pushed   = 0;

    always #5 clk = ~clk;

    clock_display_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES),
        .LZB          (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .H_in1 (H_in1),
        .H_in0 (H_in0),
        .M_in1 (M_in1),
        .M_in0 (M_in0),
        .S_in1 (S_in1),
        .S_in0 (S_in0),
        .Alarm (Alarm),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Cycle c of a frame: slot c/4, slot count c%4; digs = {H1,H0,M1,M0,S1,S0}.
    function automatic logic [W-1:0] exp_entry(input int c, input logic [23:0] digs,
                                               input logic off);
        int         i;
        int         s;
        logic [3:0] dv;
        logic [5:0] a;
        logic       d;
        i  = c / SCAN_DIV;
        s  = c % SCAN_DIV;
        dv = digs[i*4 +: 4];
        if (s < BLANK_CYC || (i == 5 && dv == 4'd0))
            return {6'h3F, 7'h7F, 1'b1, 1'b1};
        if (off)
            return {6'h3F, 7'h7F, 1'b1, 1'b0};
        a    = 6'h3F;
        a[i] = 1'b0;
        d    = (i == 4 || i == 2) ? 1'b0 : 1'b1;
        return {a, glyph_of(dv), d, 1'b1};
    endfunction

    task automatic push_frame(input logic [23:0] digs, input int off_until, input int n);
        for (int c = 0; c < n; c++) begin
            exp_q.push_back(exp_entry(c, digs, c < off_until));
            pushed++;
        end
    endtask

    task automatic set_digits(input logic [23:0] d);
        H_in1 = d[21:20];
        H_in0 = d[19:16];
        M_in1 = d[15:12];
        M_in0 = d[11:8];
        S_in1 = d[7:4];
        S_in0 = d[3:0];
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [5:0] a,
                             input logic [6:0] s, input logic d);
        checks++;
        if (an !== a || seg !== s || dp !== d) begin
            failures++;
            $display("FAIL %s: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     name, an, seg, dp, a, s, d);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            samples++;
            checks++;
            if (an !== mon_e[14:9] || dp !== mon_e[1] || (mon_e[0] && seg !== mon_e[8:2])) begin
                failures++;
                $display("FAIL scan sample %0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         samples - 1, an, seg, dp, mon_e[14:9], mon_e[8:2], mon_e[1]);
            end
        end
    end

    initial begin
        reset = 1'b0;
        Alarm = 1'b0;
        set_digits(24'h298765);
        wait_cyc(3);
        check_out("reset_hold", 6'h3F, 7'h7F, 1'b1);

        set_digits(24'h123456);
        reset = 1'b1;
        push_frame(24'h123456, 0, 24);
        push_frame(24'h123456, 0, 24);

        wait_cyc(29);
        set_digits(24'h123756);
        push_frame(24'h123756, 0, 24);

        wait_cyc(24);
        set_digits(24'h0B3756);
        push_frame(24'h0B3756, 0, 24);
        push_frame(24'h0B3756, 0, 24);
        push_frame(24'h0B3756, 0, 24);

        wait_cyc(43);
        Alarm = 1'b1;
        push_frame(24'h0B3756, 24, 24);
        push_frame(24'h0B3756, 24, 24);
        push_frame(24'h0B3756, 0, 24);
        push_frame(24'h0B3756, 0, 24);
        push_frame(24'h0B3756, 10, 24);

        wait_cyc(154);
        Alarm = 1'b0;
        push_frame(24'h0B3756, 0, 14);

        wait_cyc(28);
        reset = 1'b0;
        #1;
        check_out("async_reset", 6'h3F, 7'h7F, 1'b1);
        wait_cyc(3);
        check_out("reset_hold_mid", 6'h3F, 7'h7F, 1'b1);

        reset = 1'b1;
        push_frame(24'h0B3756, 0, 24);
        push_frame(24'h0B3756, 0, 24);
        wait_cyc(50);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: left=%0d required=0", exp_q.size());
        end
        checks++;
        if (samples != pushed) begin
            failures++;
            $display("FAIL sample_count: got=%0d required=%0d", samples, pushed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Time-multiplexed 6-digit, 7-segment display driver downstream of the alarm clock core. It consumes the six BCD time digits and the Alarm flag, and snapshots the digits once per scan frame so the display cannot tear. It drives one common-anode digit at a time with blanking gaps, and flashes the whole display while Alarm is high.

## Interface
- SCAN_DIV, 10000: clk cycles per digit slot; 10 MHz / 10000 gives 1 kHz per digit. Legal range 4..65535.
- BLANK_CYC, 100: cycles at the start of each slot with all anodes off (anti-ghosting). Must be < SCAN_DIV.
- BLINK_FRAMES, 83: completed frames per blink half-period; about 0.5 s at the defaults.
- LZB, 1: when 1, an H1 digit of 0 is blanked (leading-zero blanking).
- clk  in  1  system clock, 10 MHz.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- H_in1  in  2  hour tens digit, 0..2.
- H_in0, M_in1, M_in0, S_in1, S_in0  in  4 each  hour ones, minute tens/ones, second tens/ones digits.
- Alarm  in  1  high selects flash mode.
- an  out  6  anode enables, active-low. Bit 5 = H1 (leftmost) ... bit 0 = S0 (rightmost).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- slot_cnt counts 0..SCAN_DIV-1 and wraps. idx (0..5) increments on each slot_cnt wrap. idx 5 -> 0 completes a frame.
- Snapshot register: all six digits are captured together on the cycle where idx wraps 5 -> 0, and on the first cycle after reset release. Digits are never sampled at any other time.
- Display for slot idx:
  - Blanking: while slot_cnt < BLANK_CYC, an = all 1s and seg = all 1s.
  - Otherwise, an has bit idx low and all other bits high. seg = decode(snapshot digit idx).
- Decode:
  - Values 0..9 map to the standard glyphs.
  - Values 10..15 map to a dash: seg = 7'b0111111, segment g only.
  - H_in1 is zero-extended to 4 bits before decoding.
- Leading-zero blanking: if LZB=1 and the H1 snapshot is 0, the H1 slot behaves as a blanking slot (an all 1s).
- Decimal point: dp = 0 during the non-blank portion of idx 4 (H0) and idx 2 (M0), giving HH.MM.SS. dp = 1 at all other times.
- Blink:
  - While Alarm = 0: frame_cnt is held at 0 and phase is held at ON.
  - While Alarm = 1: frame_cnt counts completed frames. At BLINK_FRAMES-1 it clears and phase toggles.
  - When phase = OFF, an = all 1s and dp = 1 regardless of slot.
  - Alarm falling returns phase to ON on the next cycle.
- No FSM beyond the counters. The phase state machine has two states: ON <-> OFF, toggling only on frame-count terminal while Alarm = 1.

## Timing
- Reset values: an = 6'b111111, seg = 7'b1111111, dp = 1, slot_cnt = 0, idx = 0, frame_cnt = 0, phase = ON, snapshot = 0.
- All outputs are registered, with 1-cycle latency from the counter state to an/seg/dp.
- Each slot's first lit cycle is BLANK_CYC+1 cycles after slot_cnt = 0.
- Digit inputs changing mid-frame have no visible effect until the next frame boundary. The maximum capture latency is 6*SCAN_DIV cycles.
- Alarm is sampled every cycle; a phase change takes effect within 1 cycle.
- Reset asserted mid-frame forces the reset values asynchronously. After release, scanning restarts at idx 0 with slot_cnt 0.
- Simultaneous frame wrap and Alarm fall: the Alarm fall wins, so phase = ON and frame_cnt = 0.
- Counter widths: slot_cnt is 16 bits, idx is 3 bits, frame_cnt is 8 bits. BLINK_FRAMES is limited to ≤ 255.

## Structure
- Shared package clock_disp_pkg holds:
  - the SEG_0..SEG_9, SEG_DASH and SEG_OFF constants (active-low, 7 bits);
  - the digit-index constants DIG_S0..DIG_H1;
  - the phase typedef {PH_ON, PH_OFF}.
- One combinational sub-module, bcd_to_seg7: 4-bit digit in, 7-bit active-low segment pattern out. It is instantiated once, after the idx mux.

## Test plan
Benches use SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
- Reset: hold reset=0 and drive digits. Required: an=3F, seg=7F, dp=1. Release reset. Required: first lit cycle shows an=3E with the S0 glyph.
- Scan: digits 1,2,3,4,5,6 (H1..S0). Required over one frame (24 cycles): an walks 3E, 3D, 3B, 37, 2F, 1F with seg = glyph(6), (5), (4), (3), (2), (1). dp=0 only on the 3B and 2F slots. Exactly one blank cycle per slot.
- Snapshot: change M0 from 4 to 7 while idx=1. Required: the M0 slot keeps showing 4 until the next frame, then shows 7.
- Decode edge cases:
  - H0 = 4'hB: the H0 slot shows seg = 0111111.
  - H1 = 0 with LZB=1: the H1 slot keeps an = 3F throughout.
- Blink: raise Alarm. Required: an = 3F for frames 3-4, lit for frames 5-6, then repeating. Drop Alarm during an OFF frame: required lit on the next cycle.
- Async reset mid-frame: assert reset at idx=3, slot_cnt=2. Required: outputs reach reset values without a clk edge, and the scan restarts from idx 0.
